// File: rtl/switch_debouncer.sv
// Switch debouncer: synchroniser plus stability-qualified level FSM for a bouncing input.
// Optional RISE/FALL edge strobes are built only when DEBOUNCE_EDGE_DETECT_EN is defined.
module switch_debouncer #(
  parameter int unsigned CNT_MAX     = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic A,
  output logic Q,
  output logic RISE,
  output logic FALL,
  output logic BUSY
);

  localparam int unsigned CntW = $clog2(CNT_MAX + 1);

  localparam logic [1:0] S_LOW     = 2'd0;
  localparam logic [1:0] S_RISING  = 2'd1;
  localparam logic [1:0] S_HIGH    = 2'd2;
  localparam logic [1:0] S_FALLING = 2'd3;

  // The entry sample already counts as the first stable one.
  localparam logic [CntW-1:0] CntLast = CntW'(CNT_MAX - 1);
  localparam logic [CntW-1:0] CntSat  = CntW'(CNT_MAX);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [1:0]             state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   q_q, q_d;
  logic                   busy_q, busy_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], A};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    case (state_q)
      S_LOW: begin
        if (s) begin
          state_d = S_RISING;
          cnt_d   = CntOne;
        end
      end
      S_RISING: begin
        if (!s) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q >= CntLast) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          q_d     = 1'b1;
        end else if (cnt_q < CntSat) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      S_HIGH: begin
        if (!s) begin
          state_d = S_FALLING;
          cnt_d   = CntOne;
        end
      end
      S_FALLING: begin
        if (s) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q >= CntLast) begin
          state_d = S_LOW;
          cnt_d   = '0;
          q_d     = 1'b0;
        end else if (cnt_q < CntSat) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
        q_d     = 1'b0;
      end
    endcase
    busy_d = (state_d == S_RISING) || (state_d == S_FALLING);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
    end
  end

  assign Q    = q_q;
  assign BUSY = busy_q;

`ifdef DEBOUNCE_EDGE_DETECT_EN
  logic rise_q, fall_q;

  // Reset forces Q low silently, so strobes come only from qualified changes.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= q_d & ~q_q;
      fall_q <= ~q_d & q_q;
    end
  end

  assign RISE = rise_q;
  assign FALL = fall_q;
`else
  assign RISE = 1'b0;
  assign FALL = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer: directed latency scenarios plus randomized
// switch activity checked against a run-length reference model.
module tb_switch_debouncer;

  localparam int unsigned CNT_MAX     = 4;
  localparam int unsigned SYNC_STAGES = 2;
`ifdef DEBOUNCE_EDGE_DETECT_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic a;
  logic q, rise, fall, busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: delay line for the synchroniser, run length of disagreeing samples.
  logic m_sync [SYNC_STAGES];
  logic m_q;
  int   m_run;
  logic m_rise, m_fall;

  always #5 clk = ~clk;

  switch_debouncer #(
    .CNT_MAX    (CNT_MAX),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .A    (a),
    .Q    (q),
    .RISE (rise),
    .FALL (fall),
    .BUSY (busy)
  );

  task automatic model_edge(input logic r, input logic av);
    logic s_old;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (!r) begin
      for (int i = 0; i < SYNC_STAGES; i++) m_sync[i] = 1'b0;
      m_q   = 1'b0;
      m_run = 0;
    end else begin
      s_old = m_sync[SYNC_STAGES-1];
      for (int i = SYNC_STAGES - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = av;
      if (s_old !== m_q) begin
        m_run++;
        if (m_run == CNT_MAX) begin
          m_q    = ~m_q;
          m_rise = m_q;
          m_fall = ~m_q;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  function automatic logic [3:0] exp_vec();
    return {m_q, (m_run != 0), EdgeEn & m_rise, EdgeEn & m_fall};
  endfunction

  // Advance one clock edge and the model; outputs are stable on return.
  task automatic step();
    @(posedge clk);
    model_edge(rst_n, a);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    rst_n = 1'b0;
    a     = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      n_tests++;
      if ({q, busy, rise, fall} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_hold k=%0d qbrf got %b want 0000", k, {q, busy, rise, fall});
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      exp = {(k >= 6), (k >= 3 && k <= 5), EdgeEn && (k == 6), 1'b0};
      n_tests++;
      if ({q, busy, rise, fall} !== exp) begin
        n_fail++;
        $display("FAIL reset_release k=%0d qbrf got %b want %b", k, {q, busy, rise, fall}, exp);
      end
      n_tests++;
      if ({q, busy, rise, fall} !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_model k=%0d qbrf got %b want %b", k, {q, busy, rise, fall},
                 exp_vec());
      end
    end
  endtask

  task automatic test_clean_rise();
    logic [3:0] exp;
    a = 1'b0;
    for (int k = 0; k < 10; k++) step();
    a = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      exp = {(k >= 6), (k >= 3 && k <= 5), EdgeEn && (k == 6), 1'b0};
      n_tests++;
      if ({q, busy, rise, fall} !== exp) begin
        n_fail++;
        $display("FAIL clean_rise k=%0d qbrf got %b want %b", k, {q, busy, rise, fall}, exp);
      end
    end
  endtask

  task automatic test_bounce();
    a = 1'b0;
    for (int k = 0; k < 10; k++) step();
    a = 1'b1; step(); step();
    n_tests++;
    if (rise !== 1'b0 || q !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_burst q=%b rise=%b want q=0 rise=0", q, rise);
    end
    a = 1'b0; step();
    a = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      n_tests++;
      if ({q, rise} !== {(k >= 6), EdgeEn && (k == 6)} || {q, busy, rise, fall} !== exp_vec()) begin
        n_fail++;
        $display("FAIL bounce k=%0d qbrf got %b want %b (q from k>=6)", k,
                 {q, busy, rise, fall}, exp_vec());
      end
    end
  endtask

  task automatic test_glitch();
    bit saw_busy = 1'b0;
    a = 1'b1;
    for (int k = 0; k < 10; k++) step();
    a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      saw_busy |= busy;
    end
    a = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      saw_busy |= busy;
      n_tests++;
      if (q !== 1'b1 || fall !== 1'b0 || {q, busy, rise, fall} !== exp_vec()) begin
        n_fail++;
        $display("FAIL glitch k=%0d qbrf got %b want %b", k, {q, busy, rise, fall}, exp_vec());
      end
    end
    n_tests++;
    if (!saw_busy) begin
      n_fail++;
      $display("FAIL glitch_busy got busy never high want a pulse");
    end
  endtask

  task automatic test_reset_mid();
    a = 1'b1;
    for (int k = 0; k < 10; k++) step();
    a = 1'b0;
    for (int k = 1; k <= 3; k++) step();
    rst_n = 1'b0;
    step();
    n_tests++;
    if (q !== 1'b0 || fall !== 1'b0 || dut.state_q !== 2'd0 || dut.cnt_q !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_mid q=%b fall=%b state=%0d cnt=%0d want 0 0 0 0", q, fall,
               dut.state_q, dut.cnt_q);
    end
    a = 1'b1;
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_tests++;
      if (q !== (k >= 6) || {q, busy, rise, fall} !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_mid_release k=%0d qbrf got %b want %b", k, {q, busy, rise, fall},
                 exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int   hold;
    logic prev_pulse = 1'b0;
    for (int blk = 0; blk < 150; blk++) begin
      a    = 1'($urandom_range(0, 1));
      hold = (blk % 3 == 0) ? int'($urandom_range(5, 12)) : int'($urandom_range(1, 5));
      for (int k = 0; k < hold; k++) begin
        rst_n = ($urandom_range(0, 99) != 0);
        step();
        n_tests++;
        if ({q, busy, rise, fall} !== exp_vec()) begin
          n_fail++;
          $display("FAIL random blk=%0d k=%0d qbrf got %b want %b", blk, k,
                   {q, busy, rise, fall}, exp_vec());
        end
        n_tests++;
        if ((rise && fall) || (prev_pulse && (rise || fall))) begin
          n_fail++;
          $display("FAIL random_pulse blk=%0d rise=%b fall=%b prev=%b want isolated", blk, rise,
                   fall, prev_pulse);
        end
        prev_pulse = rise | fall;
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    a     = 1'b0;
    for (int i = 0; i < SYNC_STAGES; i++) m_sync[i] = 1'b0;
    m_q    = 1'b0;
    m_run  = 0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    #1;
    test_reset();
    test_clean_rise();
    test_bounce();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
